// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and types for the rename register file.
package register_file_pkg;
   localparam int REG_WIDTH = 5;
   localparam int ROB_WIDTH = 4;
   localparam int ROB_SIZE  = 2**ROB_WIDTH;
   localparam int NUM_REGS  = 2**REG_WIDTH;
   typedef logic [REG_WIDTH-1:0] reg_id_t;
   typedef logic [ROB_WIDTH-1:0] rob_id_t;
   typedef logic [31:0]          word_t;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: decoder, ROB query and commit/flush signals of the register file.
interface register_file_if;
   import register_file_pkg::*;
   reg_id_t dec_rs1;
   reg_id_t dec_rs2;
   word_t   dec_val_j;
   logic    dec_dep_j_busy;
   rob_id_t dec_dep_j;
   word_t   dec_val_k;
   logic    dec_dep_k_busy;
   rob_id_t dec_dep_k;
   logic    dec_issue;
   reg_id_t dec_rd;
   rob_id_t dec_rob_id;
   rob_id_t rob_query_id_j;
   logic    rob_ready_j;
   word_t   rob_data_j;
   rob_id_t rob_query_id_k;
   logic    rob_ready_k;
   word_t   rob_data_k;
   logic    commit_en;
   reg_id_t commit_reg_id;
   word_t   commit_data;
   rob_id_t commit_rob_id;
   logic    flush;
   modport master (
      output dec_rs1, dec_rs2, dec_issue, dec_rd, dec_rob_id,
      output rob_ready_j, rob_data_j, rob_ready_k, rob_data_k,
      output commit_en, commit_reg_id, commit_data, commit_rob_id, flush,
      input  dec_val_j, dec_dep_j_busy, dec_dep_j, dec_val_k, dec_dep_k_busy, dec_dep_k,
      input  rob_query_id_j, rob_query_id_k
   );
   modport slave (
      input  dec_rs1, dec_rs2, dec_issue, dec_rd, dec_rob_id,
      input  rob_ready_j, rob_data_j, rob_ready_k, rob_data_k,
      input  commit_en, commit_reg_id, commit_data, commit_rob_id, flush,
      output dec_val_j, dec_dep_j_busy, dec_dep_j, dec_val_k, dec_dep_k_busy, dec_dep_k,
      output rob_query_id_j, rob_query_id_k
   );
endinterface

// File: rtl/register_file_operand_resolve.sv
// register_file_operand_resolve: picks an operand from the file, a same-cycle commit, a finished ROB entry, or reports its tag.
module register_file_operand_resolve
   import register_file_pkg::*;
(
   input  reg_id_t rs_i,
   input  word_t   val_i,
   input  logic    busy_i,
   input  rob_id_t tag_i,
   input  logic    commit_en_i,
   input  rob_id_t commit_rob_id_i,
   input  word_t   commit_data_i,
   input  logic    rob_ready_i,
   input  word_t   rob_data_i,
   output word_t   val_o,
   output logic    busy_o,
   output rob_id_t dep_o
);
   logic zero, hit;
   always_comb begin
      zero   = rs_i == '0;
      hit    = commit_en_i && commit_rob_id_i == tag_i;
      val_o  = zero ? '0 : !busy_i ? val_i : hit ? commit_data_i : rob_ready_i ? rob_data_i : '0;
      busy_o = !zero && busy_i && !hit && !rob_ready_i;
      dep_o  = zero ? '0 : tag_i;
   end
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers with per-register rename tags, commit bypass and flush.
module register_file
   import register_file_pkg::*;
(
   input logic          clk_in,
   input logic          rst_in,
   input logic          rdy_in,
   register_file_if.slave rf
);
   word_t                val_q [NUM_REGS];
   word_t                val_d [NUM_REGS];
   rob_id_t              tag_q [NUM_REGS];
   rob_id_t              tag_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q, busy_d;
   // Issue is applied after commit so a rename in the same cycle keeps the register busy.
   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (rf.commit_en && rf.commit_reg_id != '0) begin
         val_d[rf.commit_reg_id] = rf.commit_data;
         if (tag_q[rf.commit_reg_id] == rf.commit_rob_id) busy_d[rf.commit_reg_id] = 1'b0;
      end
      if (rf.flush) busy_d = '0;
      else if (rf.dec_issue && rf.dec_rd != '0) begin
         busy_d[rf.dec_rd] = 1'b1;
         tag_d[rf.dec_rd]  = rf.dec_rob_id;
      end
   end
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         val_q  <= '{default: '0};
         busy_q <= '0;
         tag_q  <= '{default: '0};
      end else if (rdy_in) begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   assign rf.rob_query_id_j = tag_q[rf.dec_rs1];
   assign rf.rob_query_id_k = tag_q[rf.dec_rs2];
   register_file_operand_resolve u_j (
      .rs_i(rf.dec_rs1), .val_i(val_q[rf.dec_rs1]), .busy_i(busy_q[rf.dec_rs1]), .tag_i(tag_q[rf.dec_rs1]),
      .commit_en_i(rf.commit_en), .commit_rob_id_i(rf.commit_rob_id), .commit_data_i(rf.commit_data),
      .rob_ready_i(rf.rob_ready_j), .rob_data_i(rf.rob_data_j),
      .val_o(rf.dec_val_j), .busy_o(rf.dec_dep_j_busy), .dep_o(rf.dec_dep_j)
   );
   register_file_operand_resolve u_k (
      .rs_i(rf.dec_rs2), .val_i(val_q[rf.dec_rs2]), .busy_i(busy_q[rf.dec_rs2]), .tag_i(tag_q[rf.dec_rs2]),
      .commit_en_i(rf.commit_en), .commit_rob_id_i(rf.commit_rob_id), .commit_data_i(rf.commit_data),
      .rob_ready_i(rf.rob_ready_k), .rob_data_i(rf.rob_data_k),
      .val_o(rf.dec_val_k), .busy_o(rf.dec_dep_k_busy), .dep_o(rf.dec_dep_k)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: vector table with an expected-result queue, plus an async reset sequence.
module tb_register_file;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   register_file_if rf();
   register_file dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rf(rf));
   always #5 clk_in = ~clk_in;
   typedef struct {
      int iss, rd, rid, cen, creg, cdat, crob, fl, rdy, rs1, rs2, rrj, rdj, rrk, rdk;
      int evj, ebj, edj, evk, ebk, edk;
   } vec_t;
   vec_t vecs [19];
   vec_t exp_q [$];
   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask
   task automatic drive(input vec_t v);
      rf.dec_issue     = v.iss[0];
      rf.dec_rd        = v.rd[4:0];
      rf.dec_rob_id    = v.rid[3:0];
      rf.commit_en     = v.cen[0];
      rf.commit_reg_id = v.creg[4:0];
      rf.commit_data   = v.cdat;
      rf.commit_rob_id = v.crob[3:0];
      rf.flush         = v.fl[0];
      rdy_in           = v.rdy[0];
      rf.dec_rs1       = v.rs1[4:0];
      rf.dec_rs2       = v.rs2[4:0];
      rf.rob_ready_j   = v.rrj[0];
      rf.rob_data_j    = v.rdj;
      rf.rob_ready_k   = v.rrk[0];
      rf.rob_data_k    = v.rdk;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end
   initial begin
      vec_t e;
      vecs[0]  = '{0,0,0, 0,0,0,0, 0,1, 5,0, 0,0,0,0,          0,0,0,       0,0,0};
      vecs[1]  = '{1,3,2, 0,0,0,0, 0,1, 3,0, 0,0,0,0,          0,0,0,       0,0,0};
      vecs[2]  = '{0,0,0, 0,0,0,0, 0,1, 3,3, 0,0,1,'h55,       0,1,2,       'h55,0,0};
      vecs[3]  = '{0,0,0, 0,0,0,0, 0,1, 3,5, 1,'h55,0,0,       'h55,0,0,    0,0,0};
      vecs[4]  = '{0,0,0, 1,3,'hAB,2, 0,1, 3,3, 1,'h99,0,0,    'hAB,0,0,    'hAB,0,0};
      vecs[5]  = '{1,3,2, 0,0,0,0, 0,1, 3,3, 0,0,1,'h77,       'hAB,0,0,    'hAB,0,0};
      vecs[6]  = '{1,3,7, 0,0,0,0, 0,1, 3,0, 0,0,0,0,          0,1,2,       0,0,0};
      vecs[7]  = '{0,0,0, 1,3,'h11,2, 0,1, 3,0, 0,0,0,0,       0,1,7,       0,0,0};
      vecs[8]  = '{1,6,1, 0,0,0,0, 0,1, 3,6, 0,0,0,0,          0,1,7,       0,0,0};
      vecs[9]  = '{1,4,5, 0,0,0,0, 1,1, 6,4, 0,0,0,0,          0,1,1,       0,0,0};
      vecs[10] = '{0,0,0, 0,0,0,0, 0,1, 3,4, 0,0,0,0,          'h11,0,0,    0,0,0};
      vecs[11] = '{1,0,3, 1,0,'hFFFF,0, 0,1, 6,0, 0,0,0,0,     0,0,0,       0,0,0};
      vecs[12] = '{1,8,4, 1,9,'h1234,0, 0,0, 0,0, 1,5,0,0,     0,0,0,       0,0,0};
      vecs[13] = '{1,8,9, 0,0,0,0, 0,1, 8,9, 0,0,0,0,          0,0,0,       0,0,0};
      vecs[14] = '{1,8,10, 1,8,'hCAFE,9, 0,1, 8,8, 0,0,1,'h33, 'hCAFE,0,0,  'hCAFE,0,0};
      vecs[15] = '{0,0,0, 0,0,0,0, 1,0, 8,8, 0,0,1,'h42,       0,1,10,      'h42,0,0};
      vecs[16] = '{0,0,0, 0,0,0,0, 0,1, 8,9, 0,0,0,0,          0,1,10,      0,0,0};
      vecs[17] = '{0,0,0, 1,8,5,10, 0,1, 8,0, 0,0,0,0,         5,0,0,       0,0,0};
      vecs[18] = '{0,0,0, 0,0,0,0, 0,1, 8,3, 1,9,0,0,          5,0,0,       'h11,0,0};
      drive(vecs[0]);
      #12 rst_in = 1'b1;
      for (int i = 0; i < 19; i++) begin
         @(posedge clk_in);
         #1 drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(negedge clk_in);
         e = exp_q.pop_front();
         chk("val_j", i, rf.dec_val_j, e.evj);
         chk("busy_j", i, 32'(rf.dec_dep_j_busy), e.ebj);
         if (e.ebj != 0) chk("dep_j", i, 32'(rf.dec_dep_j), e.edj);
         chk("val_k", i, rf.dec_val_k, e.evk);
         chk("busy_k", i, 32'(rf.dec_dep_k_busy), e.ebk);
         if (e.ebk != 0) chk("dep_k", i, 32'(rf.dec_dep_k), e.edk);
      end
      @(posedge clk_in);
      #1 drive('{1,8,3, 0,0,0,0, 0,1, 0,0, 0,0,0,0, 0,0,0, 0,0,0});
      @(posedge clk_in);
      #1 drive('{0,0,0, 0,0,0,0, 0,1, 8,3, 0,0,0,0, 0,0,0, 0,0,0});
      #1;
      chk("pre_rst_busy_j", 19, 32'(rf.dec_dep_j_busy), 1);
      chk("pre_rst_query_j", 19, 32'(rf.rob_query_id_j), 3);
      rst_in = 1'b0;
      #1;
      chk("async_rst_busy_j", 20, 32'(rf.dec_dep_j_busy), 0);
      chk("async_rst_val_j", 20, rf.dec_val_j, 0);
      chk("async_rst_val_k", 20, rf.dec_val_k, 0);
      chk("async_rst_query_j", 20, 32'(rf.rob_query_id_j), 0);
      rst_in = 1'b1;
      @(posedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
